// File: rtl/ff_phase_scheduler.sv
// Sequences one sample through the LRF core array: positive phase, then an optional negative phase.
// Gates the upstream AER stream into the mapper and collects per-core finish pulses, with a drain timeout.
module ff_phase_scheduler #(
  parameter int CORE_NUM      = 64,
  parameter int EVT_CNT_WIDTH = 16,
  parameter int TIMEOUT_WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     train_en,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  input  logic                     src_req,
  input  logic                     src_last,
  output logic                     src_ack,
  output logic                     arr_req,
  input  logic                     arr_ack,
  input  logic [CORE_NUM-1:0]      core_finish,
  output logic                     is_pos,
  output logic                     is_train,
  output logic                     busy,
  output logic                     phase_done,
  output logic                     sample_done,
  output logic                     err_timeout,
  output logic [EVT_CNT_WIDTH-1:0] evt_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_POS_INJ, S_POS_DRN, S_SWITCH, S_NEG_INJ, S_NEG_DRN, S_DONE, S_ERR
  } state_t;

  state_t                   state, state_nxt;
  logic                     train_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_lim, tmo_cnt, tmo_inc;
  logic [CORE_NUM-1:0]      mask, mask_or;
  logic                     ack_q, last_flag, hold_q;
  logic                     in_inj, in_drn, fwd_open;
  logic                     ack_rise, ack_fall, mask_full, tmo_hit, go_start, inj_done;

  assign mask_or   = mask | core_finish;
  assign mask_full = &mask_or;
  assign tmo_inc   = tmo_cnt + 1'b1;
  assign tmo_hit   = (tmo_lim != '0) && (tmo_inc == tmo_lim);
  assign go_start  = start && ((state == S_IDLE) || (state == S_ERR));
  assign ack_rise  = fwd_open & arr_ack & ~ack_q;
  assign ack_fall  = fwd_open & ack_q & ~arr_ack;
  assign inj_done  = in_inj & ack_fall & last_flag;

  // Zero-cycle forwarding; hold_q keeps the window open until an in-flight handshake drains.
  assign arr_req = src_req & fwd_open;
  assign src_ack = arr_ack & fwd_open;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_ERR: if (start) state_nxt = S_POS_INJ;
      S_POS_INJ:     if (inj_done) state_nxt = S_POS_DRN;
      S_POS_DRN: begin
        if (mask_full) begin
          if (!hold_q) state_nxt = train_q ? S_SWITCH : S_DONE;
        end else if (tmo_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_SWITCH:      state_nxt = S_NEG_INJ;
      S_NEG_INJ:     if (inj_done) state_nxt = S_NEG_DRN;
      S_NEG_DRN: begin
        if (mask_full) begin
          if (!hold_q) state_nxt = S_DONE;
        end else if (tmo_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_DONE:        state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_inj   = (state == S_POS_INJ) || (state == S_NEG_INJ);
    in_drn   = (state == S_POS_DRN) || (state == S_NEG_DRN);
    busy     = (state != S_IDLE) && (state != S_ERR);
    fwd_open = in_inj | hold_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      train_q     <= 1'b0;
      tmo_lim     <= '0;
      tmo_cnt     <= '0;
      mask        <= '0;
      ack_q       <= 1'b0;
      last_flag   <= 1'b0;
      hold_q      <= 1'b0;
      is_pos      <= 1'b1;
      is_train    <= 1'b0;
      phase_done  <= 1'b0;
      sample_done <= 1'b0;
      err_timeout <= 1'b0;
      evt_cnt     <= '0;
    end else begin
      ack_q       <= arr_ack;
      hold_q      <= fwd_open & (src_req | arr_ack);
      phase_done  <= in_drn & mask_full & ~hold_q;
      sample_done <= (state == S_DONE);

      if (ack_rise) last_flag <= src_last;
      if (ack_fall && evt_cnt != '1) evt_cnt <= evt_cnt + 1'b1;

      // Entry clear loads the current pulses so a coincident finish is not lost.
      if (go_start || state == S_SWITCH) mask <= core_finish;
      else if (in_inj || in_drn)         mask <= mask_or;

      if (in_drn)   tmo_cnt <= tmo_inc;
      if (inj_done) begin
        tmo_cnt   <= '0;
        last_flag <= 1'b0;
      end

      if (in_drn && state_nxt == S_ERR) err_timeout <= 1'b1;

      if (state == S_POS_DRN && state_nxt == S_SWITCH) begin
        is_pos  <= 1'b0;
        evt_cnt <= '0;
      end
      if (state == S_DONE) is_pos <= 1'b1;

      if (go_start) begin
        train_q     <= train_en;
        tmo_lim     <= timeout_cycles;
        tmo_cnt     <= '0;
        is_pos      <= 1'b1;
        is_train    <= train_en;
        evt_cnt     <= '0;
        err_timeout <= 1'b0;
        last_flag   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ff_phase_scheduler.sv
// Directed bench for ff_phase_scheduler: the bench plays both the AER source and the mapper.
// A narrow event counter keeps the saturation case short.
module tb_ff_phase_scheduler;

  localparam int CN = 64;
  localparam int EW = 8;
  localparam int TW = 20;

  logic          clk, rst_n, start, train_en, src_req, src_last, src_ack, arr_req, arr_ack;
  logic [TW-1:0] timeout_cycles;
  logic [CN-1:0] core_finish, cf;
  logic          is_pos, is_train, busy, phase_done, sample_done, err_timeout;
  logic [EW-1:0] evt_cnt;
  int            total, bad, cnt;

  ff_phase_scheduler #(.CORE_NUM(CN), .EVT_CNT_WIDTH(EW), .TIMEOUT_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .train_en(train_en),
    .timeout_cycles(timeout_cycles), .src_req(src_req), .src_last(src_last),
    .src_ack(src_ack), .arr_req(arr_req), .arr_ack(arr_ack),
    .core_finish(core_finish), .is_pos(is_pos), .is_train(is_train), .busy(busy),
    .phase_done(phase_done), .sample_done(sample_done), .err_timeout(err_timeout),
    .evt_cnt(evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic tr, input logic [TW-1:0] lim);
    train_en       = tr;
    timeout_cycles = lim;
    start          = 1'b1;
    @(negedge clk);
    start          = 1'b0;
  endtask

  // One full 4-phase handshake; returns on the negedge after the completing edge.
  task automatic do_evt(input logic last, input logic quiet);
    src_req  = 1'b1;
    src_last = last;
    #1;
    if (!quiet) chk("evt_arr_req", arr_req, 1);
    @(negedge clk);
    arr_ack = 1'b1;
    #1;
    if (!quiet) chk("evt_src_ack", src_ack, 1);
    @(negedge clk);
    src_req  = 1'b0;
    src_last = 1'b0;
    @(negedge clk);
    arr_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic finish_all;
    core_finish = '1;
    @(negedge clk);
    core_finish = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; train_en = 1'b0; timeout_cycles = '0;
    src_req = 1'b0; src_last = 1'b0; arr_ack = 1'b0; core_finish = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_is_pos", is_pos, 1);
    chk("rst_is_train", is_train, 0);
    chk("rst_evt_cnt", evt_cnt, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_pulses", {phase_done, sample_done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Gating while idle
    src_req = 1'b1; arr_ack = 1'b1;
    #1;
    chk("idle_arr_req", arr_req, 0);
    chk("idle_src_ack", src_ack, 0);
    src_req = 1'b0; arr_ack = 1'b0;
    @(negedge clk); @(negedge clk);

    // Inference sample
    do_start(1'b0, '0);
    chk("inf_busy", busy, 1);
    chk("inf_is_train", is_train, 0);
    chk("inf_is_pos", is_pos, 1);
    repeat (4) do_evt(1'b0, 1'b0);
    do_evt(1'b1, 1'b0);
    chk("inf_evt_cnt", evt_cnt, 5);
    src_req = 1'b1;
    #1;
    chk("drn_gate_arr_req", arr_req, 0);
    src_req = 1'b0;
    train_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_ignored_train", is_train, 0);
    chk("busy_start_ignored_cnt", evt_cnt, 5);
    core_finish = '1;
    @(negedge clk);
    core_finish = '0;
    chk("inf_phase_done", phase_done, 1);
    chk("inf_sample_early", sample_done, 0);
    chk("inf_pos_hold", is_pos, 1);
    @(negedge clk);
    chk("inf_sample_done", sample_done, 1);
    chk("inf_phase_once", phase_done, 0);
    chk("inf_idle", busy, 0);
    @(negedge clk);
    chk("inf_sample_pulse", sample_done, 0);

    // Training sample with staggered finishes
    do_start(1'b1, '0);
    chk("trn_is_train", is_train, 1);
    chk("trn_is_pos", is_pos, 1);
    repeat (2) do_evt(1'b0, 1'b1);
    do_evt(1'b1, 1'b0);
    chk("trn_pos_cnt", evt_cnt, 3);
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < CN; i++) cf[i] = ((i % 10) == j);
      core_finish = cf;
      @(negedge clk);
      if (j == 8) chk("trn_partial_mask", phase_done, 0);
    end
    core_finish = '0;
    core_finish[5] = 1'b1;
    chk("trn_pos_phase_done", phase_done, 1);
    chk("trn_switch_is_pos", is_pos, 0);
    @(negedge clk);
    core_finish = '0;
    chk("trn_neg_is_pos", is_pos, 0);
    chk("trn_neg_cnt_clr", evt_cnt, 0);
    repeat (3) do_evt(1'b0, 1'b1);
    do_evt(1'b1, 1'b0);
    chk("trn_neg_cnt", evt_cnt, 4);
    core_finish = '1;
    core_finish[5] = 1'b0;
    @(negedge clk);
    core_finish = '0;
    chk("trn_neg_phase_done_kept_bit", phase_done, 1);
    chk("trn_done_is_pos", is_pos, 0);
    @(negedge clk);
    chk("trn_sample_done", sample_done, 1);
    chk("trn_is_pos_back", is_pos, 1);
    chk("trn_is_train_hold", is_train, 1);
    @(negedge clk);

    // In-flight handshake across INJ->DRN
    do_start(1'b0, '0);
    do_evt(1'b0, 1'b1);
    src_req = 1'b1; src_last = 1'b1;
    @(negedge clk);
    arr_ack = 1'b1;
    @(negedge clk);
    src_req = 1'b0; src_last = 1'b0;
    @(negedge clk);
    arr_ack = 1'b0; src_req = 1'b1;
    @(negedge clk);
    chk("inflight_arr_req_held", arr_req, 1);
    arr_ack = 1'b1;
    #1;
    chk("inflight_src_ack", src_ack, 1);
    @(negedge clk);
    src_req = 1'b0;
    @(negedge clk);
    arr_ack = 1'b0;
    @(negedge clk);
    src_req = 1'b1;
    #1;
    chk("after_inflight_gated", arr_req, 0);
    src_req = 1'b0;
    chk("inflight_cnt", evt_cnt, 3);
    core_finish = '1;
    @(negedge clk);
    core_finish = '0;
    chk("inflight_phase_done", phase_done, 1);
    @(negedge clk); @(negedge clk);

    // Timeout at 100 with core 17 silent
    do_start(1'b0, 20'd100);
    do_evt(1'b1, 1'b1);
    core_finish = '1;
    core_finish[17] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      core_finish = '0;
      cnt++;
      if (err_timeout) break;
    end
    chk("tmo_cycles", cnt, 100);
    chk("tmo_err", err_timeout, 1);
    chk("tmo_busy", busy, 0);
    @(negedge clk);
    chk("tmo_sticky", err_timeout, 1);
    src_req = 1'b1;
    #1;
    chk("err_gate", arr_req, 0);
    src_req = 1'b0;

    // Timeout disabled: waits indefinitely; start clears the error
    do_start(1'b0, '0);
    chk("restart_err_clr", err_timeout, 0);
    chk("restart_busy", busy, 1);
    do_evt(1'b1, 1'b1);
    core_finish = '1;
    core_finish[17] = 1'b0;
    @(negedge clk);
    core_finish = '0;
    repeat (300) @(negedge clk);
    chk("notmo_busy", busy, 1);
    chk("notmo_err", err_timeout, 0);
    core_finish[17] = 1'b1;
    @(negedge clk);
    core_finish = '0;
    chk("notmo_phase_done", phase_done, 1);
    @(negedge clk); @(negedge clk);

    // Mask full on the same cycle the limit is reached
    do_start(1'b0, 20'd10);
    do_evt(1'b1, 1'b1);
    core_finish = '1;
    core_finish[17] = 1'b0;
    @(negedge clk);
    core_finish = '0;
    repeat (8) @(negedge clk);
    core_finish[17] = 1'b1;
    @(negedge clk);
    core_finish = '0;
    chk("simul_phase_done", phase_done, 1);
    chk("simul_no_err", err_timeout, 0);
    @(negedge clk);
    chk("simul_sample_done", sample_done, 1);
    @(negedge clk);

    // Saturation of the event counter
    do_start(1'b0, '0);
    repeat (300) do_evt(1'b0, 1'b1);
    chk("sat_cnt", evt_cnt, 255);
    do_evt(1'b1, 1'b1);
    chk("sat_hold", evt_cnt, 255);
    finish_all();

    // Reset in NEG_INJ with a request up
    do_start(1'b1, '0);
    do_evt(1'b1, 1'b1);
    core_finish = '1;
    @(negedge clk);
    core_finish = '0;
    @(negedge clk);
    do_evt(1'b0, 1'b1);
    chk("neg_pre_rst_cnt", evt_cnt, 1);
    chk("neg_pre_rst_is_pos", is_pos, 0);
    src_req = 1'b1;
    #1;
    chk("neg_pre_rst_arr_req", arr_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_arr_req", arr_req, 0);
    chk("mid_rst_is_pos", is_pos, 1);
    chk("mid_rst_is_train", is_train, 0);
    chk("mid_rst_evt_cnt", evt_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    src_req = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
